// File: rtl/multi_sum_seq.sv
// -----------------------------------------------------------------------------
// multi_sum_seq
//
// Time-multiplexed signed summer for neuron pre-activation. On an accepted
// start the N_INPUTS operands and the bias are snapshotted. One operand per
// clock is then added into a single accumulator, and the width-adjusted result
// is presented with a one-cycle done pulse.
//
// Handshake: start is a request that is sampled only while the block is IDLE.
// A start seen during ACCUM or DONE is dropped, not queued. The rising edge
// that samples start=1 in IDLE is the accepting edge. Inputs that change after
// that edge have no effect on the result. done is a single-cycle pulse that
// marks sum/sat valid. sum/sat then hold until the next result is written.
//
// Optional feature: define MULTI_SUM_SAT_EN so that a result which does not
// fit in OUT_W is clamped to the OUT_W signed range and sat is raised. Without
// the macro the result wraps (two's complement) and sat is tied to 0.
//
// Parameters:
//   N_INPUTS - operands summed per operation (>=1)
//   DATA_W   - width of each signed operand and of bias
//   OUT_W    - width of the signed sum output (>=DATA_W)
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   start       in   request, sampled only in IDLE
//   in_flat     in   packed operands, operand k = in_flat[k*DATA_W +: DATA_W]
//   bias        in   signed bias, captured with the operands
//   busy        out  high while in ACCUM or DONE
//   sum         out  signed result, held until the next result
//   done        out  one-cycle pulse, sum/sat valid
//   sat         out  last result was clamped (0 unless MULTI_SUM_SAT_EN)
//   dbg_state_o out  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module multi_sum_seq #(
    parameter int N_INPUTS = 8,
    parameter int DATA_W   = 16,
    parameter int OUT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [N_INPUTS*DATA_W-1:0]   in_flat,
    input  logic [DATA_W-1:0]            bias,
    output logic                         busy,
    output logic [OUT_W-1:0]             sum,
    output logic                         done,
    output logic                         sat,
    output logic [1:0]                   dbg_state_o
);

    // Accumulator width is wide enough for bias plus N_INPUTS operands.
    localparam int ACC_W = DATA_W + $clog2(N_INPUTS + 1);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [N_INPUTS*DATA_W-1:0]   ops_q, ops_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [OUT_W-1:0]             sum_q, sum_d;
    logic                         sat_q, sat_d;
    logic                         done_q, done_d;

    logic [DATA_W-1:0]            cur_op;
    logic [OUT_W-1:0]             fit_w;
    logic                         ovf_w;
    logic                         sat_flag_w;

    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W - DATA_W){v[DATA_W-1]}}, v};
    endfunction

    assign cur_op = ops_q[idx_q*DATA_W +: DATA_W];

    // Width adjustment of the accumulator to the output width.
    generate
        if (OUT_W > ACC_W) begin : g_extend
            assign fit_w = {{(OUT_W - ACC_W){acc_q[ACC_W-1]}}, acc_q};
            assign ovf_w = 1'b0;
        end else if (OUT_W == ACC_W) begin : g_same
            assign fit_w = acc_q;
            assign ovf_w = 1'b0;
        end else begin : g_narrow
            // The value fits only when every bit from OUT_W-1 upward is a copy
            // of the sign bit.
            logic [ACC_W-OUT_W:0] top_bits;
            assign top_bits = acc_q[ACC_W-1:OUT_W-1];
            assign ovf_w    = !((&top_bits) || !(|top_bits));
`ifdef MULTI_SUM_SAT_EN
            assign fit_w = !ovf_w       ? acc_q[OUT_W-1:0] :
                           acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                            {1'b0, {(OUT_W-1){1'b1}}};
`else
            assign fit_w = acc_q[OUT_W-1:0];
`endif
        end
    endgenerate

`ifdef MULTI_SUM_SAT_EN
    assign sat_flag_w = ovf_w;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_w;
    assign sat_flag_w = 1'b0;
`endif

    // Next-state and datapath logic
    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ops_d   = in_flat;
                    acc_d   = sext(bias);
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + sext(cur_op);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                sum_d   = fit_w;
                sat_d   = sat_flag_w;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    // Working registers are don't-care after reset.
    always_ff @(posedge clk) begin
        ops_q <= ops_d;
        acc_q <= acc_d;
        idx_q <= idx_d;
    end

    assign busy        = (state_q == S_ACCUM) || (state_q == S_DONE);
    assign sum         = sum_q;
    assign sat         = sat_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multi_sum_seq.sv
`timescale 1ns/1ps
module tb_multi_sum_seq;

    localparam int NA      = 4;
    localparam int DA      = 8;
    localparam int OA      = 8;
    localparam int NB      = 1;
    localparam int NC      = 16;
    localparam int DW      = 16;
    localparam int OW      = 24;
    localparam int TIMEOUT = 60;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: N=4, DATA_W=8, OUT_W=8 ----------------
    logic              a_start;
    logic [NA*DA-1:0]  a_in;
    logic [DA-1:0]     a_bias;
    logic              a_busy, a_done, a_sat;
    logic [OA-1:0]     a_sum;
    logic [1:0]        a_dbg;

    multi_sum_seq #(.N_INPUTS(NA), .DATA_W(DA), .OUT_W(OA)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .in_flat(a_in), .bias(a_bias),
        .busy(a_busy), .sum(a_sum), .done(a_done), .sat(a_sat), .dbg_state_o(a_dbg)
    );

    // ---------------- DUT B: N=1, DATA_W=16, OUT_W=24 ----------------
    logic              b_start;
    logic [NB*DW-1:0]  b_in;
    logic [DW-1:0]     b_bias;
    logic              b_busy, b_done, b_sat;
    logic [OW-1:0]     b_sum;
    logic [1:0]        b_dbg;

    multi_sum_seq #(.N_INPUTS(NB), .DATA_W(DW), .OUT_W(OW)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .in_flat(b_in), .bias(b_bias),
        .busy(b_busy), .sum(b_sum), .done(b_done), .sat(b_sat), .dbg_state_o(b_dbg)
    );

    // ---------------- DUT C: N=16, DATA_W=16, OUT_W=24 ----------------
    logic              c_start;
    logic [NC*DW-1:0]  c_in;
    logic [DW-1:0]     c_bias;
    logic              c_busy, c_done, c_sat;
    logic [OW-1:0]     c_sum;
    logic [1:0]        c_dbg;

    multi_sum_seq #(.N_INPUTS(NC), .DATA_W(DW), .OUT_W(OW)) dut_c (
        .clk(clk), .reset(reset), .start(c_start), .in_flat(c_in), .bias(c_bias),
        .busy(c_busy), .sum(c_sum), .done(c_done), .sat(c_sat), .dbg_state_o(c_dbg)
    );

    // ---------------- scoreboard ----------------
    int pass_cnt;
    int total_cnt;
    logic [OA:0] exp_q[$];     // {sat, sum} for DUT A
    logic [OW:0] exp_w_q[$];   // {sat, sum} for DUT B / C
    int ops_a[NA];
    int bias_a;

    // Reference: exact integer sum, then fit to 8 bits.
    function automatic logic [OA:0] model_a();
        int s;
        s = bias_a;
        for (int k = 0; k < NA; k++) s += ops_a[k];
`ifdef MULTI_SUM_SAT_EN
        if (s > 127)  return {1'b1, 8'h7F};
        if (s < -128) return {1'b1, 8'h80};
`endif
        return {1'b0, s[OA-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_inputs_a();
        for (int k = 0; k < NA; k++) a_in[k*DA +: DA] = DA'(ops_a[k]);
        a_bias = DA'(bias_a);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_a();
        drive_inputs_a();
        a_start = 1'b1;
        exp_q.push_back(model_a());
        @(negedge clk);
        a_start = 1'b0;
    endtask

    // Cycles from the accepting edge until done; -1 on timeout.
    task automatic wait_done_a(output int lat);
        lat = 0;
        while (a_done !== 1'b1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        if (a_done !== 1'b1) lat = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else pass_cnt++;
        total_cnt++; if (a_done !== 1'b0) $display("FAIL reset_done: got %b want 0", a_done); else pass_cnt++;
        total_cnt++; if (a_sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", a_sum); else pass_cnt++;
        total_cnt++; if (a_sat !== 1'b0) $display("FAIL reset_sat: got %b want 0", a_sat); else pass_cnt++;
        total_cnt++; if (a_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", a_dbg); else pass_cnt++;
        total_cnt++; if (b_sum !== 24'h0 || c_sum !== 24'h0) $display("FAIL reset_sum_wide: got %h/%h want 0/0", b_sum, c_sum); else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        bit busy_ok;
        logic [OA:0] exp;
        ops_a = '{10, 20, 30, 40};
        bias_a = 0;
        start_a();
        busy_ok = (a_busy === 1'b1);
        lat = 0;
        while (a_done !== 1'b1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
            if (a_done !== 1'b1 && a_busy !== 1'b1) busy_ok = 1'b0;
        end
        exp = exp_q.pop_front();
        total_cnt++; if (lat !== NA + 1) $display("FAIL basic_latency: got %0d want %0d", lat, NA + 1); else pass_cnt++;
        total_cnt++; if (!busy_ok) $display("FAIL basic_busy: busy dropped during operation"); else pass_cnt++;
        total_cnt++; if (a_sum !== 8'd100) $display("FAIL basic_sum_const: got %h want 64", a_sum); else pass_cnt++;
        total_cnt++; if ({a_sat, a_sum} !== exp) $display("FAIL basic_sum: got %h want %h", {a_sat, a_sum}, exp); else pass_cnt++;
        total_cnt++; if (a_busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", a_busy); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (a_done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", a_done); else pass_cnt++;
        total_cnt++; if (a_sum !== 8'd100) $display("FAIL basic_hold: got %h want 64", a_sum); else pass_cnt++;
    endtask

    task automatic test_bias_neg();
        int lat;
        int dones;
        logic [OA:0] exp;
        ops_a = '{-5, 3, -7, 1};
        bias_a = 2;
        start_a();
        wait_done_a(lat);
        exp = exp_q.pop_front();
        total_cnt++; if (lat !== NA + 1) $display("FAIL bias_latency: got %0d want %0d", lat, NA + 1); else pass_cnt++;
        total_cnt++; if (a_sum !== 8'hFA) $display("FAIL bias_sum_const: got %h want fa", a_sum); else pass_cnt++;
        total_cnt++; if ({a_sat, a_sum} !== exp) $display("FAIL bias_sum: got %h want %h", {a_sat, a_sum}, exp); else pass_cnt++;
        // new operands without a start must not disturb the result
        a_in = 32'($urandom());
        a_bias = 8'($urandom_range(0, 255));
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_done === 1'b1) dones++;
        end
        total_cnt++; if (a_sum !== 8'hFA) $display("FAIL bias_hold: got %h want fa", a_sum); else pass_cnt++;
        total_cnt++; if (dones !== 0) $display("FAIL bias_no_start: got %0d done pulses want 0", dones); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int lat;
        logic [OA:0] exp;
        ops_a = '{100, 100, 100, 100};
        bias_a = 0;
        start_a();
        wait_done_a(lat);
        exp = exp_q.pop_front();
`ifdef MULTI_SUM_SAT_EN
        total_cnt++; if ({a_sat, a_sum} !== 9'h17F) $display("FAIL ovf_pos_const: got %h want 17f", {a_sat, a_sum}); else pass_cnt++;
`else
        total_cnt++; if ({a_sat, a_sum} !== 9'h090) $display("FAIL ovf_pos_const: got %h want 090", {a_sat, a_sum}); else pass_cnt++;
`endif
        total_cnt++; if ({a_sat, a_sum} !== exp) $display("FAIL ovf_pos: got %h want %h", {a_sat, a_sum}, exp); else pass_cnt++;
        @(negedge clk);
        ops_a = '{-128, -128, -128, -128};
        bias_a = 0;
        start_a();
        wait_done_a(lat);
        exp = exp_q.pop_front();
`ifdef MULTI_SUM_SAT_EN
        total_cnt++; if ({a_sat, a_sum} !== 9'h180) $display("FAIL ovf_neg_const: got %h want 180", {a_sat, a_sum}); else pass_cnt++;
`else
        total_cnt++; if ({a_sat, a_sum} !== 9'h000) $display("FAIL ovf_neg_const: got %h want 000", {a_sat, a_sum}); else pass_cnt++;
`endif
        total_cnt++; if ({a_sat, a_sum} !== exp) $display("FAIL ovf_neg: got %h want %h", {a_sat, a_sum}, exp); else pass_cnt++;
        @(negedge clk);
    endtask

    // start held high: accepts at E, E+6, E+12; done after E+5, E+11, E+17.
    task automatic test_back_to_back();
        int bad_timing;
        int seen;
        logic [OA:0] exp;
        ops_a = '{1, 2, 3, 4};
        bias_a = 5;
        drive_inputs_a();
        a_start = 1'b1;
        exp_q.push_back(model_a());
        @(negedge clk);
        bad_timing = 0;
        seen = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k == 0) begin
                ops_a = '{-1, -2, -3, -4}; bias_a = -10;
                drive_inputs_a();
                exp_q.push_back(model_a());
            end
            if (k == 6) begin
                ops_a = '{50, -60, 70, -80}; bias_a = 3;
                drive_inputs_a();
                exp_q.push_back(model_a());
            end
            if (k == 12) begin
                a_start = 1'b0;
                a_in = 32'hDEADBEEF;
            end
            if (k == 5 || k == 11 || k == 17) begin
                if (a_done !== 1'b1) bad_timing++;
                exp = exp_q.pop_front();
                seen++;
                total_cnt++;
                if ({a_sat, a_sum} !== exp) $display("FAIL b2b_sum_%0d: got %h want %h", seen, {a_sat, a_sum}, exp);
                else pass_cnt++;
            end else if (a_done === 1'b1) begin
                bad_timing++;
            end
            @(negedge clk);
        end
        total_cnt++; if (bad_timing !== 0) $display("FAIL b2b_timing: got %0d misplaced done cycles want 0", bad_timing); else pass_cnt++;
    endtask

    task automatic test_ignore_busy();
        int dones;
        int done_k;
        ops_a = '{7, 8, 9, 10};
        bias_a = 1;
        start_a();
        dones = 0;
        done_k = -1;
        for (int k = 0; k <= 14; k++) begin
            if (k == 2) begin
                ops_a = '{-100, -100, -100, -100};
                drive_inputs_a();
                a_start = 1'b1;
            end
            if (k == 3) a_start = 1'b0;
            if (a_done === 1'b1) begin
                dones++;
                done_k = k;
                total_cnt++;
                if ({a_sat, a_sum} !== exp_q[0]) $display("FAIL ignore_sum: got %h want %h", {a_sat, a_sum}, exp_q[0]);
                else pass_cnt++;
            end
            @(negedge clk);
        end
        void'(exp_q.pop_front());
        total_cnt++; if (dones !== 1 || done_k !== NA + 1) $display("FAIL ignore_pulses: got %0d pulses at %0d want 1 at %0d", dones, done_k, NA + 1); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int dones;
        int lat;
        logic [OA:0] exp;
        ops_a = '{11, 22, 33, 44};
        bias_a = 0;
        start_a();
        @(negedge clk);          // second ACCUM cycle
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_front());
        total_cnt++; if (a_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", a_busy); else pass_cnt++;
        total_cnt++; if (a_sum !== 8'h00) $display("FAIL rstmid_sum: got %h want 00", a_sum); else pass_cnt++;
        total_cnt++; if (a_done !== 1'b0 || a_sat !== 1'b0) $display("FAIL rstmid_done_sat: got %b%b want 00", a_done, a_sat); else pass_cnt++;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_done === 1'b1) dones++;
        end
        total_cnt++; if (dones !== 0) $display("FAIL rstmid_no_done: got %0d pulses want 0", dones); else pass_cnt++;
        ops_a = '{1, -2, 3, -4};
        bias_a = 100;
        start_a();
        wait_done_a(lat);
        exp = exp_q.pop_front();
        total_cnt++; if (lat !== NA + 1) $display("FAIL rstmid_latency: got %0d want %0d", lat, NA + 1); else pass_cnt++;
        total_cnt++; if ({a_sat, a_sum} !== exp) $display("FAIL rstmid_sum_after: got %h want %h", {a_sat, a_sum}, exp); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        // N_INPUTS = 1
        for (int t = 0; t < 6; t++) begin
            longint s;
            int lat;
            logic signed [DW-1:0] v;
            logic [OW:0] exp;
            v = (t == 0) ? 16'sh8000 : (t == 1) ? 16'sh7FFF : DW'($urandom_range(0, 65535));
            b_bias = (t == 0) ? 16'h8000 : (t == 1) ? 16'h7FFF : DW'($urandom_range(0, 65535));
            b_in = v;
            s = longint'(v) + longint'($signed(b_bias));
            exp_w_q.push_back({1'b0, s[OW-1:0]});
            b_start = 1'b1;
            @(negedge clk);
            b_start = 1'b0;
            b_in = DW'($urandom());
            lat = 0;
            while (b_done !== 1'b1 && lat < TIMEOUT) begin
                @(negedge clk);
                lat++;
            end
            exp = exp_w_q.pop_front();
            total_cnt++; if (lat !== NB + 1) $display("FAIL sweep1_latency_%0d: got %0d want %0d", t, lat, NB + 1); else pass_cnt++;
            total_cnt++; if ({b_sat, b_sum} !== exp) $display("FAIL sweep1_sum_%0d: got %h want %h", t, {b_sat, b_sum}, exp); else pass_cnt++;
            @(negedge clk);
        end
        // N_INPUTS = 16
        for (int t = 0; t < 6; t++) begin
            longint s;
            int lat;
            logic signed [DW-1:0] v;
            logic [OW:0] exp;
            c_bias = (t == 0) ? 16'h8000 : (t == 1) ? 16'h7FFF : DW'($urandom_range(0, 65535));
            s = longint'($signed(c_bias));
            for (int k = 0; k < NC; k++) begin
                v = (t == 0) ? 16'sh8000 : (t == 1) ? 16'sh7FFF : DW'($urandom_range(0, 65535));
                c_in[k*DW +: DW] = v;
                s += longint'(v);
            end
            exp_w_q.push_back({1'b0, s[OW-1:0]});
            c_start = 1'b1;
            @(negedge clk);
            c_start = 1'b0;
            c_in = '0;
            lat = 0;
            while (c_done !== 1'b1 && lat < TIMEOUT) begin
                @(negedge clk);
                lat++;
            end
            exp = exp_w_q.pop_front();
            total_cnt++; if (lat !== NC + 1) $display("FAIL sweep16_latency_%0d: got %0d want %0d", t, lat, NC + 1); else pass_cnt++;
            total_cnt++; if ({c_sat, c_sum} !== exp) $display("FAIL sweep16_sum_%0d: got %h want %h", t, {c_sat, c_sum}, exp); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        reset = 1'b1;
        a_start = 1'b0; a_in = '0; a_bias = '0;
        b_start = 1'b0; b_in = '0; b_bias = '0;
        c_start = 1'b0; c_in = '0; c_bias = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_bias_neg();
        test_overflow();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
